// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: load/shift/done sequencer and Mealy carry FSM for an
// N-bit LSB-first serial adder. Operand and sum shift registers live outside.
module serial_add_ctrl #(
    parameter int unsigned N = 8,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cin,
    input  logic          a_bit,
    input  logic          b_bit,
    output logic          ld,
    output logic          shift_en,
    output logic          sum_bit,
    output logic          cout,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_carry;
    logic          w_next_carry;
    logic [CW-1:0] r_bit_cnt;
    logic [CW-1:0] w_next_bit_cnt;
    logic          r_cout;
    logic          w_next_cout;
    logic          w_maj;

    // Carry generated by the current bit position.
    assign w_maj = (a_bit & b_bit) | (a_bit & r_carry) | (b_bit & r_carry);

    // State, carry, bit counter and final carry registers; reset wins over all.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
            r_cout    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_carry   <= w_next_carry;
            r_bit_cnt <= w_next_bit_cnt;
            r_cout    <= w_next_cout;
        end
    end

    // Next-state logic and control/Mealy sum outputs.
    always_comb begin
        w_next_state   = r_state;
        w_next_carry   = r_carry;
        w_next_bit_cnt = r_bit_cnt;
        w_next_cout    = r_cout;
        ld             = 1'b0;
        shift_en       = 1'b0;
        sum_bit        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                    w_next_carry = cin;
                end
            end
            S_LOAD: begin
                ld             = 1'b1;
                busy           = 1'b1;
                w_next_bit_cnt = '0;
                w_next_state   = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en     = 1'b1;
                busy         = 1'b1;
                sum_bit      = a_bit ^ b_bit ^ r_carry;
                w_next_carry = w_maj;
                if (r_bit_cnt == CW'(N - 1)) begin
                    w_next_state   = S_DONE;
                    w_next_cout    = w_maj;
                    w_next_bit_cnt = '0;
                end else begin
                    w_next_bit_cnt = r_bit_cnt + CW'(1);
                end
            end
            S_DONE: begin
                done           = 1'b1;
                busy           = 1'b1;
                w_next_carry   = 1'b0;
                w_next_bit_cnt = '0;
                w_next_state   = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bit_cnt = r_bit_cnt;
    assign cout    = r_cout;

endmodule
